reset_sequencer: RTL

- Downstream consumer of the synchronized reset. Takes the already-synchronized, active-high `reset` and releases NUM_STAGES domain resets one at a time, in order.
- Each later stage is released only after the previous stage reports ready and a fixed settling delay has elapsed.
- Reports overall readiness and per-stage timeout errors to the system controller.
- Supports a software-initiated re-sequence.

---
 rtl/reset_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NUM_STAGES domain resets in index order, waiting for each
// stage's ready plus a settling delay, with per-stage timeout detection and software restart.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8,
  parameter int TIMEOUT     = 256
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         sw_reset,
  input  logic [NUM_STAGES-1:0]                        stage_ready,
  output logic [NUM_STAGES-1:0]                        rst_out,
  output logic                                         all_ready,
  output logic                                         timeout_err,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] err_stage
);

  localparam int IW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int MAXA = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int MAXC = (MAXA > TIMEOUT) ? MAXA : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    ASSERT,
    WAIT_RDY,
    DELAY,
    DONE,
    ERROR
  } state_t;

  state_t                  state, stateNext;
  logic [CW-1:0]           cnt, cntNext;
  logic [IW-1:0]           idx, idxNext;
  logic [NUM_STAGES-1:0]   rstNext;
  logic                    allReadyNext;
  logic                    timeoutErrNext;
  logic [IW-1:0]           errStageNext;

  // Software restart shares the hardware reset values; hardware reset still wins by ordering.
  always_ff @(posedge clk) begin
    if (reset || sw_reset) begin
      state       <= ASSERT;
      cnt         <= '0;
      idx         <= '0;
      rst_out     <= '1;
      all_ready   <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      idx         <= idxNext;
      rst_out     <= rstNext;
      all_ready   <= allReadyNext;
      timeout_err <= timeoutErrNext;
      err_stage   <= errStageNext;
    end
  end

  // Next-state and next-output logic; the counter restarts from zero on every transition.
  always_comb begin
    stateNext      = state;
    cntNext        = cnt + 1'b1;
    idxNext        = idx;
    rstNext        = rst_out;
    allReadyNext   = all_ready;
    timeoutErrNext = timeout_err;
    errStageNext   = err_stage;

    case (state)
      ASSERT: begin
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
          stateNext  = WAIT_RDY;
          cntNext    = '0;
          idxNext    = '0;
          rstNext[0] = 1'b0;
        end
      end

      WAIT_RDY: begin
        if (stage_ready[idx]) begin
          cntNext = '0;
          if (idx == IW'(NUM_STAGES - 1)) begin
            stateNext    = DONE;
            allReadyNext = 1'b1;
          end else begin
            stateNext = DELAY;
          end
        end else if ((TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1))) begin
          stateNext      = ERROR;
          cntNext        = '0;
          timeoutErrNext = 1'b1;
          errStageNext   = idx;
          rstNext        = '1;
          allReadyNext   = 1'b0;
        end
      end

      DELAY: begin
        if (cnt == CW'(STAGE_DELAY - 1)) begin
          stateNext = WAIT_RDY;
          cntNext   = '0;
          idxNext   = idx + 1'b1;
          rstNext   = rst_out & ~(NUM_STAGES'(2) << idx);
        end
      end

      DONE: begin
        cntNext      = cnt;
        allReadyNext = &stage_ready;
      end

      ERROR: begin
        cntNext        = cnt;
        rstNext        = '1;
        allReadyNext   = 1'b0;
        timeoutErrNext = 1'b1;
      end

      default: begin
        stateNext = ASSERT;
        cntNext   = '0;
        idxNext   = '0;
        rstNext   = '1;
      end
    endcase
  end

endmodule
